// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: instruction/PC aliases, opcode and format enums,
// the decoded-instruction record and the major-opcode constants.
package rv32_pkg;

  localparam int HART_CNT_W = 1;

  typedef logic [31:0]           rv32_instr_t;
  typedef logic [31:0]           rv32_pc_cnt_t;
  typedef logic [HART_CNT_W-1:0] rv32_hart_cnt_t;
  typedef logic [4:0]            rv32_register_t;
  typedef logic [12:0]           rv32_csr_t;
  typedef logic [31:0]           rv32_imm_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;

  localparam rv32_instr_t INSTR_NOP    = 32'h0000_0013;
  localparam rv32_instr_t INSTR_ECALL  = 32'h0000_0073;
  localparam rv32_instr_t INSTR_EBREAK = 32'h0010_0073;
  localparam rv32_instr_t INSTR_MRET   = 32'h3020_0073;
  localparam rv32_instr_t INSTR_WFI    = 32'h1050_0073;

  typedef enum logic [7:0] {
    RV32_UNKNOWN = 8'd0,
    RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
    RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
    RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
    RV32_SB, RV32_SH, RV32_SW,
    RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
    RV32_SLLI, RV32_SRLI, RV32_SRAI,
    RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU,
    RV32_XOR, RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
    RV32_FENCE, RV32_FENCE_I,
    RV32_ECALL, RV32_EBREAK, RV32_MRET, RV32_WFI,
    RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI,
    RV32_NOP
  } rv32_opcode_enum_t;

  typedef enum logic [3:0] {
    RV32_TYPE_UNKNOWN = 4'd0,
    RV32_TYPE_R,
    RV32_TYPE_I,
    RV32_TYPE_S,
    RV32_TYPE_B,
    RV32_TYPE_U,
    RV32_TYPE_J,
    RV32_TYPE_NOP
  } rv32_inst_type_t;

  // 124 bits; raw fields ride along so execute never needs the original word
  typedef struct packed {
    rv32_opcode_enum_t opcode;
    rv32_inst_type_t   inst_type;
    rv32_instr_t       instr;
    logic [6:0]        major;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    rv32_register_t    rd;
    rv32_register_t    rs1;
    rv32_register_t    rs2;
    rv32_csr_t         csr;
    rv32_imm_t         imm;
    logic              rd_we;
    logic              rs1_re;
    logic              rs2_re;
  } rv32_inst_dec_t;

  typedef struct packed {
    rv32_inst_dec_t dec;
    rv32_pc_cnt_t   pc;
    rv32_hart_cnt_t hart;
    logic           illegal;
  } rv32_dec_bundle_t;

  function automatic rv32_imm_t sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv32_decoder_comb.sv
// Purely combinational RV32I decoder: raw word in, decoded record plus illegal flag out.
// Illegal words come out fully zeroed apart from the UNKNOWN opcode/type tags.
module rv32_decoder_comb
  import rv32_pkg::*;
(
  input  rv32_instr_t    instr_i,
  output rv32_inst_dec_t dec_o,
  output logic           illegal_o
);

  logic [6:0] major;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_alt_ok;

  assign major     = instr_i[6:0];
  assign f3        = instr_i[14:12];
  assign f7        = instr_i[31:25];
  assign f7_alt_ok = (f7 == F7_BASE) || (f7 == F7_ALT);

  rv32_opcode_enum_t op;
  rv32_inst_type_t   ty;
  rv32_imm_t         imm;
  logic use_rd, use_rs1, use_rs2, rd_we, rs1_re, is_csr, bad;

  always_comb begin
    op      = RV32_UNKNOWN;
    ty      = RV32_TYPE_UNKNOWN;
    imm     = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    rd_we   = 1'b0;
    rs1_re  = 1'b0;
    is_csr  = 1'b0;
    bad     = 1'b0;
    case (major)
      OPC_OP: begin
        ty = RV32_TYPE_R;
        {use_rd, use_rs1, use_rs2, rd_we, rs1_re} = 5'b11111;
        case (f3)
          3'b000: begin op = instr_i[30] ? RV32_SUB : RV32_ADD; bad = !f7_alt_ok; end
          3'b001: begin op = RV32_SLL;  bad = (f7 != F7_BASE); end
          3'b010: begin op = RV32_SLT;  bad = (f7 != F7_BASE); end
          3'b011: begin op = RV32_SLTU; bad = (f7 != F7_BASE); end
          3'b100: begin op = RV32_XOR;  bad = (f7 != F7_BASE); end
          3'b101: begin op = instr_i[30] ? RV32_SRA : RV32_SRL; bad = !f7_alt_ok; end
          3'b110: begin op = RV32_OR;   bad = (f7 != F7_BASE); end
          default: begin op = RV32_AND; bad = (f7 != F7_BASE); end
        endcase
      end
      OPC_OP_IMM: begin
        ty = RV32_TYPE_I;
        {use_rd, use_rs1, rd_we, rs1_re} = 4'b1111;
        imm = sext12(instr_i[31:20]);
        case (f3)
          3'b000: op = RV32_ADDI;
          3'b010: op = RV32_SLTI;
          3'b011: op = RV32_SLTIU;
          3'b100: op = RV32_XORI;
          3'b110: op = RV32_ORI;
          3'b111: op = RV32_ANDI;
          3'b001: begin
            op  = RV32_SLLI;
            imm = {27'b0, instr_i[24:20]};
            bad = (f7 != F7_BASE);
          end
          default: begin
            op  = instr_i[30] ? RV32_SRAI : RV32_SRLI;
            imm = {27'b0, instr_i[24:20]};
            bad = !f7_alt_ok;
          end
        endcase
        if (instr_i == INSTR_NOP) begin
          op  = RV32_NOP;
          ty  = RV32_TYPE_NOP;
          imm = '0;
          {use_rd, use_rs1, rd_we, rs1_re} = 4'b0000;
        end
      end
      OPC_LOAD: begin
        ty = RV32_TYPE_I;
        {use_rd, use_rs1, rd_we, rs1_re} = 4'b1111;
        imm = sext12(instr_i[31:20]);
        case (f3)
          3'b000:  op = RV32_LB;
          3'b001:  op = RV32_LH;
          3'b010:  op = RV32_LW;
          3'b100:  op = RV32_LBU;
          3'b101:  op = RV32_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ty = RV32_TYPE_S;
        {use_rs1, use_rs2, rs1_re} = 3'b111;
        imm = sext12({instr_i[31:25], instr_i[11:7]});
        case (f3)
          3'b000:  op = RV32_SB;
          3'b001:  op = RV32_SH;
          3'b010:  op = RV32_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        ty = RV32_TYPE_B;
        {use_rs1, use_rs2, rs1_re} = 3'b111;
        imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        case (f3)
          3'b000:  op = RV32_BEQ;
          3'b001:  op = RV32_BNE;
          3'b100:  op = RV32_BLT;
          3'b101:  op = RV32_BGE;
          3'b110:  op = RV32_BLTU;
          3'b111:  op = RV32_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        ty = RV32_TYPE_J;
        op = RV32_JAL;
        {use_rd, rd_we} = 2'b11;
        imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        ty  = RV32_TYPE_I;
        op  = RV32_JALR;
        {use_rd, use_rs1, rd_we, rs1_re} = 4'b1111;
        imm = sext12(instr_i[31:20]);
        bad = (f3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        ty  = RV32_TYPE_U;
        op  = (major == OPC_LUI) ? RV32_LUI : RV32_AUIPC;
        {use_rd, rd_we} = 2'b11;
        imm = {instr_i[31:12], 12'b0};
      end
      OPC_MISC_MEM: begin
        ty  = RV32_TYPE_I;
        {use_rd, use_rs1} = 2'b11;
        imm = sext12(instr_i[31:20]);
        case (f3)
          3'b000:  op = RV32_FENCE;
          3'b001:  op = RV32_FENCE_I;
          default: bad = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        ty  = RV32_TYPE_I;
        imm = sext12(instr_i[31:20]);
        // privileged ops only match exact encodings; CSRxI keeps zimm in rs1
        case (f3)
          3'b001:  op = RV32_CSRRW;
          3'b010:  op = RV32_CSRRS;
          3'b011:  op = RV32_CSRRC;
          3'b101:  op = RV32_CSRRWI;
          3'b110:  op = RV32_CSRRSI;
          3'b111:  op = RV32_CSRRCI;
          default: bad = 1'b1;
        endcase
        if (f3 != 3'b000 && f3 != 3'b100) begin
          is_csr = 1'b1;
          {use_rd, use_rs1, rd_we} = 3'b111;
          rs1_re = !f3[2];
        end
        if      (instr_i == INSTR_ECALL)  begin op = RV32_ECALL;  bad = 1'b0; end
        else if (instr_i == INSTR_EBREAK) begin op = RV32_EBREAK; bad = 1'b0; end
        else if (instr_i == INSTR_MRET)   begin op = RV32_MRET;   bad = 1'b0; end
        else if (instr_i == INSTR_WFI)    begin op = RV32_WFI;    bad = 1'b0; end
      end
      default: bad = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) bad = 1'b1;
  end

  always_comb begin
    dec_o     = '0;
    illegal_o = bad;
    if (!bad) begin
      dec_o.opcode    = op;
      dec_o.inst_type = ty;
      dec_o.instr     = instr_i;
      dec_o.major     = major;
      dec_o.funct3    = f3;
      dec_o.funct7    = f7;
      dec_o.rd        = use_rd  ? instr_i[11:7]  : '0;
      dec_o.rs1       = use_rs1 ? instr_i[19:15] : '0;
      dec_o.rs2       = use_rs2 ? instr_i[24:20] : '0;
      dec_o.csr       = is_csr  ? {1'b0, instr_i[31:20]} : '0;
      dec_o.imm       = imm;
      dec_o.rd_we     = rd_we;
      dec_o.rs1_re    = rs1_re;
      dec_o.rs2_re    = use_rs2;
    end else begin
      dec_o.opcode    = RV32_UNKNOWN;
      dec_o.inst_type = RV32_TYPE_UNKNOWN;
    end
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// Pipelined decode stage: combinational decode into an output register backed by
// a one-entry skid register so in_ready comes straight from a flop.
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int HART_W    = 1,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic [HART_W-1:0]    in_hart,
  output logic                 out_valid,
  input  logic                 out_ready,
  output rv32_inst_dec_t       out_dec,
  output logic [31:0]          out_pc,
  output logic [HART_W-1:0]    out_hart,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  typedef struct packed {
    rv32_inst_dec_t      dec;
    logic [31:0]         pc;
    logic [HART_W-1:0]   hart;
    logic                illegal;
  } entry_t;

  rv32_inst_dec_t in_dec;
  logic           in_ill;
  entry_t         in_entry;

  rv32_decoder_comb u_decoder (
    .instr_i   (in_instr),
    .dec_o     (in_dec),
    .illegal_o (in_ill)
  );

  assign in_entry = '{dec: in_dec, pc: in_pc, hart: in_hart, illegal: in_ill};

  entry_t               out_q, out_d, skid_q, skid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 accept, out_free;

  // a word presented alongside flush is dropped, so it never reaches the counter
  assign accept   = in_valid && in_ready_q && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    ill_cnt_d    = ill_cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
    if (accept && in_ill && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      ill_cnt_q    <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_dec     = out_q.dec;
  assign out_pc      = out_q.pc;
  assign out_hart    = out_q.hart;
  assign out_illegal = out_q.illegal;
  assign ill_cnt     = ill_cnt_q;

endmodule
